// File: rtl/packer_sched_pkg.sv
// Shared types for the round-robin packing scheduler.
// Holds the FSM state enum and the source-ID width helper.
package packer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT
  } sched_state_e;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packer_lane.sv
// Packing lane: FACTOR*IN_WIDTH register filled one slice per beat.
// A clear at frame start discards any previous frame contents.
module packer_lane #(
  parameter int FACTOR   = 3,
  parameter int IN_WIDTH = 8,
  localparam int CW      = $clog2(FACTOR)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr_i,
  input  logic                       load_i,
  input  logic [CW-1:0]              idx_i,
  input  logic [IN_WIDTH-1:0]        din_i,
  output logic [FACTOR*IN_WIDTH-1:0] lane_o
);

  logic [FACTOR*IN_WIDTH-1:0] lane_q;

  // Write the slice picked by the beat index, or clear for a new frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lane_q <= '0;
    end else if (clr_i) begin
      lane_q <= '0;
    end else if (load_i) begin
      lane_q[int'(idx_i)*IN_WIDTH +: IN_WIDTH] <= din_i;
    end
  end

  assign lane_o = lane_q;

endmodule

// File: rtl/packer_rr_sched.sv
// Round-robin scheduler sharing one packing lane between requesters.
// Optional stall abort: define PACKER_SCHED_TIMEOUT_EN.
module packer_rr_sched
  import packer_sched_pkg::*;
#(
  parameter int FACTOR   = 3,
  parameter int IN_WIDTH = 8,
  parameter int NUM_REQ  = 2,
  parameter int TIMEOUT  = 16,
  localparam int SW      = src_w(NUM_REQ),
  localparam int CW      = $clog2(FACTOR)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][IN_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [FACTOR*IN_WIDTH-1:0]       out_data,
  output logic [SW-1:0]                    out_src,
  output logic                             err_timeout
);

  sched_state_e         state_q;
  logic [SW-1:0]        grant_q;
  logic [SW-1:0]        last_q;
  logic [CW-1:0]        beat_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 ovalid_q;
  logic                 arb_hit;
  logic [SW-1:0]        arb_idx;
  logic [SW-1:0]        cand;
  logic                 accept;
  logic                 last_beat;
  logic                 tmo_hit;

  // Pick the first valid requester after the last one served.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = SW'((int'(last_q) + i) % NUM_REQ);
      if (!arb_hit && req_valid[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign accept    = ready_q[grant_q] && req_valid[grant_q];
  assign last_beat = (beat_q == CW'(FACTOR - 1));

`ifdef PACKER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_q;
  logic          err_q;

  // Count consecutive beat-less cycles within a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (state_q == COLLECT && !accept && !tmo_hit) begin
      stall_q <= stall_q + 1'b1;
    end else begin
      stall_q <= '0;
    end
  end

  assign tmo_hit     = (state_q == COLLECT) && !accept &&
                       (stall_q == TW'(TIMEOUT - 1));
  assign err_timeout = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT;
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Frame FSM: arbitrate, collect FACTOR beats, hold the packed word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= SW'(NUM_REQ - 1);
      beat_q   <= '0;
      ready_q  <= '0;
      ovalid_q <= 1'b0;
`ifdef PACKER_SCHED_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef PACKER_SCHED_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (arb_hit) begin
            grant_q <= arb_idx;
            ready_q <= NUM_REQ'(1) << arb_idx;
            beat_q  <= '0;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (last_beat) begin
              ready_q  <= '0;
              ovalid_q <= 1'b1;
              beat_q   <= '0;
              state_q  <= EMIT;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end else if (tmo_hit) begin
            ready_q <= '0;
            beat_q  <= '0;
            last_q  <= grant_q;
            state_q <= IDLE;
`ifdef PACKER_SCHED_TIMEOUT_EN
            err_q   <= 1'b1;
`endif
          end
        end
        EMIT: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            last_q   <= grant_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  packer_lane #(
    .FACTOR  (FACTOR),
    .IN_WIDTH(IN_WIDTH)
  ) u_lane (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (state_q == IDLE && arb_hit),
    .load_i(accept),
    .idx_i (beat_q),
    .din_i (req_data[grant_q]),
    .lane_o(out_data)
  );

  assign req_ready = ready_q;
  assign out_valid = ovalid_q;
  assign out_src   = grant_q;

endmodule
